uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10: clock cycles per serial bit, legal range 2..1023.
REQ-002 SHALL have parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port tx_data, input, 8: byte to transmit, sampled only on accept.
REQ-006 SHALL have port tx_valid, input, 1: producer has a byte on tx_data.
REQ-007 SHALL have port tx_ready, output, 1: block can accept a byte this cycle.
REQ-008 SHALL have port serial_out, output, 1: UART line, idle high, driven from a flop.
REQ-009 SHALL have port tx_busy, output, 1: high while a frame is on the line.
REQ-010 SHALL have port tx_done, output, 1: one-cycle pulse at frame end.

Function
REQ-011 SHALL accept a byte in any cycle where tx_valid and tx_ready are both high (accept cycle N); no other cycle accepts.
REQ-012 SHALL capture tx_data into an internal shift register at accept; later tx_data changes SHALL NOT affect the frame.
REQ-013 SHALL use states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_EN=0.
REQ-014 SHALL transition IDLE->START on accept, START->DATA, DATA->PARITY or STOP after bit 7, PARITY->STOP, and STOP->IDLE or STOP->START.
REQ-015 SHALL hold every bit for exactly CLKS_PER_BIT cycles, timed by a bit-cycle counter cleared at each bit boundary.
REQ-016 SHALL drive serial_out low (start bit) from cycle N+1 through N+CLKS_PER_BIT.
REQ-017 SHALL send data bits LSB first, using a 3-bit counter that wraps 7->0 on leaving DATA.
REQ-018 SHALL compute the parity bit as the XOR of the captured byte, so total ones over data+parity is even.
REQ-019 SHALL drive the stop bit high for CLKS_PER_BIT cycles.
REQ-020 SHALL drive tx_ready high in IDLE and in the last cycle of STOP only; low otherwise, and low during rst.
REQ-021 SHALL go STOP->START when an accept occurs in the last STOP cycle, giving back-to-back frames with no idle gap; otherwise SHALL go STOP->IDLE.
REQ-022 SHALL pulse tx_done high for exactly one cycle, the cycle after the last stop-bit cycle, whether or not a new frame follows.
REQ-023 SHALL drive tx_busy high from N+1 until the last stop-bit cycle inclusive, and continuously across back-to-back frames.
REQ-024 SHALL give a frame length of (10+PARITY_EN)*CLKS_PER_BIT cycles.
REQ-025 SHALL ignore tx_valid while tx_ready is low; the producer must hold tx_valid and tx_data until accept.

Reset
REQ-026 SHALL, while rst is high at a clock edge, set state=IDLE, counters=0, serial_out=1, tx_busy=0, tx_done=0, tx_ready=0.
REQ-027 SHALL let tx_ready rise in the first cycle after rst deasserts.
REQ-028 SHALL, on rst mid-frame, abort the frame, drive serial_out=1 from the next edge, emit no tx_done, and discard the captured byte.
REQ-029 SHALL give rst priority over a simultaneous tx_valid; no accept occurs in a reset cycle.

Verification
REQ-030 SHALL verify single byte (CLKS_PER_BIT=10, PARITY_EN=0): 0xA5 accepted at N -> line 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles from N+1; tx_done at N+101; tx_busy high N+1..N+100.
REQ-031 SHALL verify parity (PARITY_EN=1): 0x01 -> parity bit 1; 0xA5 -> parity bit 0; frame 110 cycles.
REQ-032 SHALL verify back-to-back: tx_valid held high with 0x55 then 0x0F -> second start bit begins at N+101 with no idle cycle; tx_busy stays high; two tx_done pulses 100 cycles apart.
REQ-033 SHALL verify data stability: tx_data changed every cycle after accept -> transmitted bits equal the value at accept.
REQ-034 SHALL verify reset mid-frame: rst pulsed during data bit 3 -> serial_out=1 next edge, no tx_done; tx_ready high the cycle after rst drops, and the next frame is correct.
REQ-035 SHALL verify backpressure: tx_valid asserted while tx_busy is high and not in the last stop cycle -> no accept until tx_ready is high; accepted byte is sent intact.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a valid/ready input handshake.
// Frame = start bit (0), eight data bits LSB first, optional even parity bit,
// stop bit (1). Every bit lasts CLKS_PER_BIT clock cycles. A byte offered
// during the last stop-bit cycle is accepted and its start bit follows
// immediately, so frames can run back-to-back without an idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       tx_done
);

  // 10 bits covers the whole legal CLKS_PER_BIT range (2..1023).
  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;       // cycles spent in the current bit
  logic [2:0]       idx_reg, idx_next;       // data bit index, wraps 7->0
  logic [7:0]       shift_reg, shift_next;   // captured byte, shifted right per data bit
  logic             parity_reg, parity_next; // even parity of the captured byte
  logic             serial_reg, serial_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic bit_end;
  logic accept;

  // Last cycle of the bit currently on the line.
  assign bit_end = (cnt_reg == BIT_LAST);

  // Ready only when idle or in the final stop-bit cycle; reset blocks any accept.
  assign tx_ready = ~rst & ((state_reg == IDLE) | ((state_reg == STOP) & bit_end));
  assign accept   = tx_valid & tx_ready;

  assign serial_out = serial_reg;
  assign tx_busy    = busy_reg;
  assign tx_done    = done_reg;

  // Next-state, counter, datapath and registered-output logic.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    serial_next = 1'b1;
    busy_next   = 1'b0;
    done_next   = 1'b0;

    // The bit-cycle counter runs in every non-idle state and clears at each bit boundary.
    if (state_reg != IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        idx_next = '0;
        if (accept) begin
          state_next  = START;
          shift_next  = tx_data;
          parity_next = ^tx_data;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = {1'b0, shift_reg[7:1]};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
            state_next = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (accept) begin
            state_next  = START;
            shift_next  = tx_data;
            parity_next = ^tx_data;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        idx_next   = '0;
      end
    endcase

    // Line level for the cycle after this edge follows the state we are entering.
    case (state_next)
      IDLE:    serial_next = 1'b1;
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_next[0];
      PARITY:  serial_next = parity_next;
      STOP:    serial_next = 1'b1;
      default: serial_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
    // Pulse lands in the cycle right after the final stop-bit cycle.
    done_next = (state_reg == STOP) & bit_end;
  end

  // State and output registers; reset aborts any frame and drops the captured byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      serial_reg <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      serial_reg <= serial_next;
      busy_reg   <= busy_next;
      done_reg   <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx. Two instances (no parity / even
// parity) share stimulus through a select; accepted bytes are queued with their
// accept cycle and an independent line monitor checks every frame cycle.
module tb_uart_tx;

  localparam int CPB = 10;

  typedef struct packed {
    logic [7:0] b;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       sel = 1'b0;

  logic valid0, valid1;
  logic ready0, serial0, busy0, done0;
  logic ready1, serial1, busy1, done1;
  logic tx_ready, tx_serial, tx_busy, tx_done;

  assign valid0    = tx_valid & ~sel;
  assign valid1    = tx_valid & sel;
  assign tx_ready  = sel ? ready1  : ready0;
  assign tx_serial = sel ? serial1 : serial0;
  assign tx_busy   = sel ? busy1   : busy0;
  assign tx_done   = sel ? done1   : done0;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid0),
    .tx_ready(ready0), .serial_out(serial0), .tx_busy(busy0), .tx_done(done0)
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(valid1),
    .tx_ready(ready1), .serial_out(serial1), .tx_busy(busy1), .tx_done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   checks = 0;
  int   fails = 0;
  int   idle_bad = 0;
  int   last_acc = 0;
  exp_t q[$];
  bit   mon_active = 1'b0;
  bit   mon_pending = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer a byte and hold it until accepted; leaves tx_valid high on return.
  task automatic send(input logic [7:0] b);
    int   w = 0;
    exp_t e;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    while (tx_ready !== 1'b1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (tx_ready !== 1'b1) begin
      check("accept timeout", 0, 1);
    end else begin
      e.b   = b;
      e.acc = cyc;
      q.push_back(e);
      last_acc = cyc;
      $display("send: byte %02h accepted at cycle %0d (parity_en=%0d)", b, cyc, sel);
    end
    @(posedge clk);
    #1;
  endtask

  // Wait until every queued frame has been seen on the line.
  task automatic drain(input bit scramble);
    int w = 0;
    while ((q.size() != 0 || mon_active || mon_pending) && w < 3000) begin
      @(negedge clk);
      if (scramble) tx_data = 8'($urandom);
      w++;
    end
    check("drain completed in time", 32'(w < 3000), 1);
    @(negedge clk);
  endtask

  // Line monitor: reference frame built from the queued byte, compared cycle by cycle.
  initial begin : monitor
    exp_t       cur;
    logic [10:0] ebits;
    logic [7:0] rx;
    logic       rxp;
    int         flen, mcyc, bi, bl, bb, br, pe;
    bit         pend_now;
    cur = '0; ebits = '0; rx = '0; rxp = 1'b0;
    flen = 0; mcyc = 0; bi = 0; bl = 0; bb = 0; br = 0; pe = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mon_active  = 1'b0;
        mon_pending = 1'b0;
        continue;
      end
      pend_now = mon_pending;
      if (mon_pending) begin
        check($sformatf("tx_done after frame %02h", cur.b), 32'(tx_done), 1);
        mon_pending = 1'b0;
      end
      if (!mon_active) begin
        if (tx_serial === 1'b0) begin
          if (q.size() == 0) begin
            idle_bad++;
          end else begin
            cur = q.pop_front();
            pe  = int'(sel);
            check($sformatf("start latency %02h", cur.b), cyc, cur.acc + 1);
            ebits = '1;
            ebits[0] = 1'b0;
            for (int i = 0; i < 8; i++) ebits[i+1] = cur.b[i];
            if (pe != 0) ebits[9] = 1'($countones(cur.b) % 2);
            flen = (10 + pe) * CPB;
            mcyc = 0; bl = 0; bb = 0; br = 0; rx = '0; rxp = 1'b0;
            mon_active = 1'b1;
          end
        end else begin
          if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || (!pend_now && tx_done !== 1'b0))
            idle_bad++;
        end
      end
      if (mon_active) begin
        bi = mcyc / CPB;
        if (tx_serial !== ebits[bi]) bl++;
        if (mcyc % CPB == CPB / 2) begin
          if (bi >= 1 && bi <= 8) rx[bi-1] = tx_serial;
          if (pe != 0 && bi == 9) rxp = tx_serial;
        end
        if (tx_busy !== 1'b1) bb++;
        if (mcyc > 0 && tx_done !== 1'b0) bb++;
        if (tx_ready !== 1'(mcyc == flen - 1)) br++;
        mcyc++;
        if (mcyc == flen) begin
          mon_active  = 1'b0;
          mon_pending = 1'b1;
          $display("mon: frame %02h received %02h ending cycle %0d", cur.b, rx, cyc);
          check($sformatf("line waveform errors %02h", cur.b), bl, 0);
          check($sformatf("received byte %02h", cur.b), rx, cur.b);
          if (pe != 0)
            check($sformatf("parity bit %02h", cur.b), rxp, $countones(cur.b) % 2);
          check($sformatf("busy/done errors %02h", cur.b), bb, 0);
          check($sformatf("ready errors %02h", cur.b), br, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  initial begin : stimulus
    int acc1, dc, gap;
    logic [7:0] b;
    // Reset state of both instances.
    repeat (3) @(negedge clk);
    check("reset serial0", serial0, 1);
    check("reset busy0", busy0, 0);
    check("reset done0", done0, 0);
    check("reset ready0", ready0, 0);
    check("reset serial1", serial1, 1);
    check("reset ready1", ready1, 0);
    rst = 1'b0;
    #1;
    check("ready after reset", ready0, 1);

    // Single byte.
    send(8'hA5);
    tx_valid = 1'b0;
    drain(1'b0);

    // Back-to-back with tx_valid held high.
    send(8'h55);
    acc1 = last_acc;
    send(8'h0F);
    tx_valid = 1'b0;
    check("back-to-back accept spacing", last_acc - acc1, 10 * CPB);
    drain(1'b0);

    // Data stability: tx_data scrambled after accept.
    send(8'h3C);
    tx_valid = 1'b0;
    drain(1'b1);

    // Backpressure: offer while busy.
    send(8'h96);
    tx_valid = 1'b0;
    repeat (30) @(negedge clk);
    send(8'hE7);
    tx_valid = 1'b0;
    drain(1'b0);

    // Reset during data bit 3.
    send(8'hC3);
    tx_valid = 1'b0;
    repeat (45) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort serial", serial0, 1);
    check("abort busy", busy0, 0);
    check("abort done", done0, 0);
    check("abort ready in reset", ready0, 0);
    rst = 1'b0;
    #1;
    check("ready after abort", ready0, 1);
    dc = 0;
    repeat (25) begin
      @(negedge clk);
      if (done0 !== 1'b0) dc++;
    end
    check("no tx_done after abort", dc, 0);
    check("queue empty after abort", q.size(), 0);
    send(8'h5A);
    tx_valid = 1'b0;
    drain(1'b0);

    // Random traffic, mixing back-to-back and gapped frames.
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      send(b);
      gap = int'($urandom_range(0, 2));
      if (gap != 0) begin
        tx_valid = 1'b0;
        repeat (int'($urandom_range(0, 150))) @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    drain(1'b0);

    // Even-parity instance.
    @(negedge clk);
    sel = 1'b1;
    send(8'h01);
    tx_valid = 1'b0;
    drain(1'b0);
    send(8'hA5);
    tx_valid = 1'b0;
    drain(1'b0);
    send(8'hFF);
    acc1 = last_acc;
    send(8'h80);
    tx_valid = 1'b0;
    check("parity back-to-back spacing", last_acc - acc1, 11 * CPB);
    drain(1'b0);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send(b);
      if ($urandom_range(0, 1) != 0) begin
        tx_valid = 1'b0;
        repeat (int'($urandom_range(0, 120))) @(negedge clk);
      end
    end
    tx_valid = 1'b0;
    drain(1'b0);

    check("idle-state violations", idle_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
